// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM emulator: decodes quad-mode READ (03) / WRITE (02) transactions
// nibble-serially from one core lane and backs them with on-chip RAM.
module idli_sqi_mem_m #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs_n,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CTR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    state_t              state, state_n;
    logic [CTR_W-1:0]    ctr, ctr_n;
    logic                rd_mode, rd_mode_n;
    logic [3:0]          cmd_hi, cmd_hi_n;
    logic [3:0]          wr_hi, wr_hi_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                sck_q;
    logic [3:0]          sio_q, sio_n;
    logic                oe_q, oe_n;

    logic                rise_c, fall_c;
    logic                we_c;
    logic [7:0]          wdata_c;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          rd_data;

    assign rise_c       = i_mem_sck & ~sck_q;
    assign fall_c       = ~i_mem_sck & sck_q;
    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

    // State and datapath registers
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state   <= ST_IDLE;
            ctr     <= '0;
            rd_mode <= 1'b0;
            cmd_hi  <= 4'h0;
            wr_hi   <= 4'h0;
            addr    <= '0;
            sck_q   <= 1'b0;
            sio_q   <= 4'h0;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_n;
            ctr     <= ctr_n;
            rd_mode <= rd_mode_n;
            cmd_hi  <= cmd_hi_n;
            wr_hi   <= wr_hi_n;
            addr    <= addr_n;
            sck_q   <= i_mem_sck;
            sio_q   <= sio_n;
            oe_q    <= oe_n;
        end
    end

    // RAM: synchronous read of the current address doubles as the prefetch
    // for the next byte, since falls are always at least two clocks apart.
    always_ff @(posedge i_mem_gck) begin
        if (we_c && !i_mem_rst) begin
            mem[addr] <= wdata_c;
        end
        rd_data <= mem[addr];
    end

    // Next-state and datapath decode
    always_comb begin
        state_n   = state;
        ctr_n     = ctr;
        rd_mode_n = rd_mode;
        cmd_hi_n  = cmd_hi;
        wr_hi_n   = wr_hi;
        addr_n    = addr;
        sio_n     = sio_q;
        oe_n      = oe_q;
        we_c      = 1'b0;
        wdata_c   = {wr_hi, i_mem_sio};

        if (i_mem_cs_n) begin
            state_n = ST_IDLE;
            ctr_n   = '0;
            oe_n    = 1'b0;
            sio_n   = 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_CMD;
                    ctr_n   = '0;
                end
                ST_CMD: begin
                    if (rise_c) begin
                        cmd_hi_n = i_mem_sio;
                        if (ctr == CTR_W'(1)) begin
                            ctr_n = '0;
                            case ({cmd_hi, i_mem_sio})
                                8'h03: begin
                                    state_n   = ST_ADDR;
                                    rd_mode_n = 1'b1;
                                end
                                8'h02: begin
                                    state_n   = ST_ADDR;
                                    rd_mode_n = 1'b0;
                                end
                                default: state_n = ST_IGNORE;
                            endcase
                        end else begin
                            ctr_n = CTR_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    // Shifting through an ADDR_W register drops the upper bits
                    if (rise_c) begin
                        addr_n = {addr[ADDR_W-5:0], i_mem_sio};
                        if (ctr == CTR_W'(5)) begin
                            ctr_n   = '0;
                            state_n = rd_mode ? ST_DUMMY : ST_WDATA;
                        end else begin
                            ctr_n = ctr + CTR_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise_c && ctr != CTR_W'(2)) begin
                        ctr_n = ctr + CTR_W'(1);
                    end
                    if (fall_c && ctr == CTR_W'(2)) begin
                        state_n = ST_RDATA;
                        sio_n   = rd_data[7:4];
                        oe_n    = 1'b1;
                        ctr_n   = CTR_W'(1);
                    end
                end
                ST_RDATA: begin
                    // ctr[0] set means the low nibble of the current byte is next
                    if (fall_c) begin
                        if (ctr[0]) begin
                            sio_n  = rd_data[3:0];
                            addr_n = addr + ADDR_W'(1);
                            ctr_n  = '0;
                        end else begin
                            sio_n = rd_data[7:4];
                            ctr_n = CTR_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise_c) begin
                        if (!ctr[0]) begin
                            wr_hi_n = i_mem_sio;
                            ctr_n   = CTR_W'(1);
                        end else begin
                            we_c   = 1'b1;
                            addr_n = addr + ADDR_W'(1);
                            ctr_n  = '0;
                        end
                    end
                end
                ST_IGNORE: begin
                    oe_n  = 1'b0;
                    sio_n = 4'h0;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: table of write/read-back vectors
// plus hand sequences for reset, wrap, unknown command and truncated frames.
module tb_idli_sqi_mem_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       oe;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;
    vec_t vecs[5];

    idli_sqi_mem_m #(.ADDR_W(16)) dut (
        .i_mem_gck    (clk),
        .i_mem_rst    (rst),
        .i_mem_sck    (sck),
        .i_mem_cs_n   (cs_n),
        .i_mem_sio    (sio_in),
        .o_mem_sio    (sio_out),
        .o_mem_sio_oe (oe)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One sck cycle carrying nib; mode 1 pops an expected read nibble after
    // the fall, mode 2 requires the output to be idle after the fall.
    task automatic pulse(input logic [3:0] nib, input int mode);
        logic [3:0] e;
        sio_in = nib;
        sck    = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(1);
        if (mode == 1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got oe=%b sio=%h with no expected nibble", oe, sio_out);
            end else begin
                e = exp_q.pop_front();
                check("rd_nibble", {3'b000, oe, sio_out}, {4'h1, e});
            end
        end else if (mode == 2) begin
            check("no_drive", {3'b000, oe, sio_out}, 8'h00);
        end
        tick(1);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        tick(2);
        check("idle_after_cs", {3'b000, oe, sio_out}, 8'h00);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        pulse(cmd[7:4], 0);
        pulse(cmd[3:0], 0);
        for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4], 0);
    endtask

    task automatic write2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
        cs_start();
        send_hdr(8'h02, a);
        pulse(b0[7:4], 0);
        pulse(b0[3:0], 0);
        pulse(b1[7:4], 0);
        pulse(b1[3:0], 0);
        cs_end();
    endtask

    // Reads n bytes (1..4); expected bytes packed MSB-first in exp_bytes
    task automatic read_n(input logic [23:0] a, input int n, input logic [31:0] exp_bytes);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = exp_bytes[31 - 8*i -: 8];
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
        cs_start();
        send_hdr(8'h03, a);
        pulse(4'h0, 0);
        for (int i = 0; i < 2*n; i++) pulse(4'h0, 1);
        cs_end();
        check("sb_drain", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{addr: 24'h000010, b0: 8'hA5, b1: 8'h3C};
        vecs[1] = '{addr: 24'h00FFFF, b0: 8'h11, b1: 8'h22};
        vecs[2] = '{addr: 24'h001234, b0: 8'hDE, b1: 8'hAD};
        vecs[3] = '{addr: 24'h008000, b0: 8'h00, b1: 8'hFF};
        vecs[4] = '{addr: 24'h000020, b0: 8'h00, b1: 8'h55};

        rst    = 1'b1;
        sck    = 1'b0;
        cs_n   = 1'b0;
        sio_in = 4'h0;
        tick(2);

        // Reset held with cs_n low and sck toggling
        pulse(4'h0, 2);
        pulse(4'h2, 2);
        for (int i = 0; i < 4; i++) pulse(4'(i + 5), 2);
        cs_n = 1'b1;
        rst  = 1'b0;
        tick(2);
        check("post_reset", {3'b000, oe, sio_out}, 8'h00);

        foreach (vecs[i]) write2(vecs[i].addr, vecs[i].b0, vecs[i].b1);
        foreach (vecs[i]) read_n(vecs[i].addr, 2, {vecs[i].b0, vecs[i].b1, 16'h0000});

        // Wrapped byte written through FFFF+1
        read_n(24'h000000, 1, 32'h2200_0000);
        // Upper address bits beyond ADDR_W are dropped
        read_n(24'hAB1234, 2, 32'hDEAD_0000);

        // Reset arrives on the rise that would complete a byte write
        cs_start();
        send_hdr(8'h02, 24'h000010);
        pulse(4'hF, 0);
        rst = 1'b1;
        pulse(4'h0, 0);
        cs_n = 1'b1;
        rst  = 1'b0;
        tick(2);
        read_n(24'h000010, 2, 32'hA53C_0000);

        // Unknown command: no write, never drives
        cs_start();
        pulse(4'h9, 2);
        pulse(4'hF, 2);
        for (int i = 0; i < 8; i++) pulse(4'($urandom_range(0, 15)), 2);
        cs_end();
        read_n(24'h000010, 1, 32'hA500_0000);

        // Odd trailing nibble is discarded
        cs_start();
        send_hdr(8'h02, 24'h000020);
        pulse(4'h7, 0);
        pulse(4'hE, 0);
        pulse(4'h4, 0);
        cs_end();
        read_n(24'h000020, 2, 32'h7E55_0000);

        // Frame aborted mid-address; next transaction must decode cleanly
        cs_start();
        pulse(4'h0, 0);
        pulse(4'h2, 0);
        pulse(4'h0, 0);
        pulse(4'h0, 0);
        cs_end();
        read_n(24'h001234, 2, 32'hDEAD_0000);

        // Deselect in the same cycle as a rise must not capture data
        cs_start();
        send_hdr(8'h02, 24'h008000);
        pulse(4'hC, 0);
        sio_in = 4'h3;
        sck    = 1'b1;
        cs_n   = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(2);
        check("cs_rise_idle", {3'b000, oe, sio_out}, 8'h00);
        read_n(24'h008000, 2, 32'h00FF_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1);
    end

endmodule
